// File: rtl/fc_layer_seq.sv
// fc_layer_seq: time-multiplexed fully-connected layer, LANES MACs per beat, serial saturated neuron outputs
module fc_layer_seq #(
  parameter int IN_W  = 10,
  parameter int W_W   = 16,
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int LANES = 4,
  parameter int OUT_W = 32,
  parameter int RELU  = 0
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [N_IN*IN_W-1:0]                  i_data,
  input  logic                                  i_w_we,
  input  logic [$clog2(N_OUT*N_IN+N_OUT)-1:0]   i_w_addr,
  input  logic [W_W-1:0]                        i_w_data,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic [OUT_W-1:0]                      o_result,
  output logic [$clog2(N_OUT)-1:0]              o_idx,
  output logic                                  o_last
);
  localparam int B     = N_IN / LANES;
  localparam int DEPTH = N_OUT * N_IN + N_OUT;
  localparam int AW    = $clog2(DEPTH);
  localparam int NW    = $clog2(N_OUT);
  localparam int XW    = N_IN > 1 ? $clog2(N_IN) : 1;
  localparam int BW    = B > 1 ? $clog2(B) : 1;
  localparam int ACC_W = IN_W + W_W + $clog2(N_IN + 1);
  localparam int SW    = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_nx;

  logic [NW-1:0]           n;
  logic [BW-1:0]           b;
  logic signed [ACC_W-1:0] acc, beat_sum, acc_nx;
  logic signed [IN_W-1:0]  xv [N_IN];
  logic signed [W_W-1:0]   mem [DEPTH];
  logic signed [SW-1:0]    tot;
  logic [OUT_W-1:0]        sat_v, res;
  logic                    last_beat;

  assign o_ready   = state == IDLE;
  assign last_beat = b == BW'(B - 1);

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    if (state == IDLE && i_valid) state_nx = MAC;
    if (state == MAC && last_beat) state_nx = OUT;
    if (state == OUT && i_ready) state_nx = n == NW'(N_OUT - 1) ? IDLE : MAC;
  end

  always_comb begin
    beat_sum = '0;
    for (int l = 0; l < LANES; l++)
      beat_sum += ACC_W'(xv[XW'(int'(b) * LANES + l)]) * ACC_W'(mem[AW'(int'(n) * N_IN + int'(b) * LANES + l)]);
  end

  assign acc_nx = acc + beat_sum;
  assign tot    = SW'(acc_nx) + SW'(mem[AW'(N_OUT * N_IN + int'(n))]);

  // The full sum carries one guard bit above the accumulator, so clamping is only needed when that exceeds OUT_W
  generate
    if (SW > OUT_W) begin : g_sat
      logic ovf;
      assign ovf   = tot[SW-1:OUT_W-1] != {(SW-OUT_W+1){tot[SW-1]}};
      assign sat_v = ovf ? {tot[SW-1], {(OUT_W-1){~tot[SW-1]}}} : tot[OUT_W-1:0];
    end else begin : g_ext
      assign sat_v = OUT_W'(tot);
    end
  endgenerate

  assign res = (RELU != 0 && sat_v[OUT_W-1]) ? '0 : sat_v;

  // Memory and vector register are deliberately not reset
  always_ff @(posedge i_clk) begin
    if (o_ready && i_w_we && 32'(i_w_addr) < DEPTH) mem[i_w_addr] <= i_w_data;
    if (o_ready && i_valid)
      for (int k = 0; k < N_IN; k++) xv[k] <= i_data[k*IN_W +: IN_W];
  end

  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      acc      <= '0;
      n        <= '0;
      b        <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_idx    <= '0;
      o_last   <= 1'b0;
    end else begin
      if (state == IDLE && i_valid) begin
        n   <= '0;
        b   <= '0;
        acc <= '0;
      end
      if (state == MAC) begin
        b   <= last_beat ? '0 : b + BW'(1);
        acc <= acc_nx;
        if (last_beat) begin
          o_valid  <= 1'b1;
          o_result <= res;
          o_idx    <= n;
          o_last   <= n == NW'(N_OUT - 1);
        end
      end
      if (state == OUT && i_ready) begin
        o_valid <= 1'b0;
        acc     <= '0;
        n       <= n + NW'(1);
      end
    end
endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq: directed + randomized checks of two fc_layer_seq variants against an arithmetic model
module tb_fc_layer_seq;
  localparam int IN_W = 10, W_W = 16, N_IN = 16, N_OUT = 10, LANES = 4, B = 4;
  localparam int DEPTH = N_OUT * N_IN + N_OUT, AW = 8;

  logic i_clk = 0, i_reset = 1, i_valid = 0, i_w_we = 0, i_ready = 1;
  logic [N_IN*IN_W-1:0] i_data = '0;
  logic [AW-1:0] i_w_addr = '0;
  logic [W_W-1:0] i_w_data = '0;
  logic o_ready0, o_valid0, o_last0, o_ready1, o_valid1, o_last1;
  logic [23:0] o_result0;
  logic [31:0] o_result1;
  logic [3:0] o_idx0, o_idx1;
  int cmp = 0, fails = 0;
  int wt[DEPTH];
  int xs[N_IN];

  always #5 i_clk = ~i_clk;

  // dut0: narrow saturating output; dut1: full width with ReLU
  fc_layer_seq #(.IN_W(IN_W), .W_W(W_W), .N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .OUT_W(24), .RELU(0)) dut0 (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready0), .i_data(i_data),
    .i_w_we(i_w_we), .i_w_addr(i_w_addr), .i_w_data(i_w_data), .o_valid(o_valid0), .i_ready(i_ready),
    .o_result(o_result0), .o_idx(o_idx0), .o_last(o_last0));
  fc_layer_seq #(.IN_W(IN_W), .W_W(W_W), .N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .OUT_W(32), .RELU(1)) dut1 (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready1), .i_data(i_data),
    .i_w_we(i_w_we), .i_w_addr(i_w_addr), .i_w_data(i_w_data), .o_valid(o_valid1), .i_ready(i_ready),
    .o_result(o_result1), .o_idx(o_idx1), .o_last(o_last1));

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    cmp++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(int n, int ow, bit relu);
    longint s, mx;
    s = wt[N_OUT*N_IN+n];
    for (int k = 0; k < N_IN; k++) s += longint'(xs[k]) * wt[n*N_IN+k];
    mx = (longint'(1) <<< (ow - 1)) - 1;
    if (s > mx) s = mx;
    if (s < -mx - 1) s = -mx - 1;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  task automatic wr(input int a, input int d);
    i_w_we = 1;
    i_w_addr = AW'(a);
    i_w_data = W_W'(d);
    if (a < DEPTH) wt[a] = d;
    tick;
    i_w_we = 0;
  endtask

  task automatic load(input int mode);
    int v;
    for (int a = 0; a < DEPTH; a++) begin
      case (mode)
        0: v = a < 160 ? 1 : 0;
        1: v = a < 160 ? a / N_IN - 5 : 100 * (a - 160);
        2: v = a < 160 ? a / N_IN - 5 : 0;
        3: v = a < 160 ? -32768 : 0;
        default: v = int'($urandom_range(0, 65535)) - 32768;
      endcase
      wr(a, v);
    end
  endtask

  task automatic check_outs(input int n);
    chk("result0", $signed(o_result0), model(n, 24, 0));
    chk("result1", $signed(o_result1), model(n, 32, 1));
    chk("idx0", o_idx0, n);
    chk("idx1", o_idx1, n);
    chk("last0", o_last0, n == N_OUT - 1);
    chk("valid1", o_valid1, 1);
  endtask

  task automatic run_vector(input int stall_n, input bit poke, input int abort_n);
    int cnt, wd;
    chk("ready_before0", o_ready0, 1);
    chk("ready_before1", o_ready1, 1);
    for (int k = 0; k < N_IN; k++) i_data[k*IN_W +: IN_W] = IN_W'(xs[k]);
    if (poke) begin
      wd = int'($urandom_range(0, 65535)) - 32768;
      i_w_we = 1;
      i_w_addr = AW'(5);
      i_w_data = W_W'(wd);
      wt[5] = wd;
    end
    i_valid = 1;
    tick;
    i_valid = 0;
    i_w_we = 0;
    for (int n = 0; n < N_OUT; n++) begin
      cnt = 0;
      while (!o_valid0 && cnt < 40) begin
        if (poke && n == 1 && cnt == 1) begin
          i_w_we = 1;
          i_w_addr = AW'(N_IN + 12);
          i_w_data = 16'h7ff3;
        end
        if (abort_n == n && cnt == 2) begin
          i_reset = 1;
          #1;
          chk("abort_valid0", o_valid0, 0);
          chk("abort_ready0", o_ready0, 1);
          chk("abort_ready1", o_ready1, 1);
          tick;
          tick;
          i_reset = 0;
          for (int i = 0; i < 8; i++) begin
            tick;
            chk("abort_quiet", o_valid0 | o_valid1, 0);
          end
          return;
        end
        tick;
        i_w_we = 0;
        cnt++;
      end
      chk("latency", cnt, B);
      check_outs(n);
      if (stall_n == n) begin
        i_ready = 0;
        for (int i = 0; i < 7; i++) begin
          tick;
          chk("stall_valid", o_valid0, 1);
          chk("stall_idx", o_idx0, n);
          chk("stall_result", $signed(o_result0), model(n, 24, 0));
        end
        i_ready = 1;
      end
      if (poke && n == 2) begin
        i_data = ~i_data;
        i_valid = 1;
      end
      tick;
      i_valid = 0;
      chk("valid_drop0", o_valid0, 0);
      chk("valid_drop1", o_valid1, 0);
    end
    chk("ready_after0", o_ready0, 1);
    chk("ready_after1", o_ready1, 1);
    if (poke)
      for (int i = 0; i < 8; i++) begin
        tick;
        chk("no_extra", o_valid0 | o_valid1, 0);
      end
  endtask

  initial begin
    tick;
    tick;
    chk("rst_valid0", o_valid0, 0);
    chk("rst_valid1", o_valid1, 0);
    chk("rst_result0", o_result0, 0);
    chk("rst_idx0", o_idx0, 0);
    chk("rst_last0", o_last0, 0);
    chk("rst_ready0", o_ready0, 1);
    chk("rst_ready1", o_ready1, 1);
    i_reset = 0;
    tick;
    load(0);
    foreach (xs[k]) xs[k] = 1;
    chk("ones_model", model(3, 24, 0), 16);
    run_vector(-1, 0, -1);
    load(1);
    foreach (xs[k]) xs[k] = -2;
    chk("ramp_model0", model(0, 24, 0), 160);
    chk("ramp_model9", model(9, 24, 0), 772);
    run_vector(-1, 0, -1);
    load(2);
    run_vector(-1, 0, -1);
    load(3);
    foreach (xs[k]) xs[k] = -512;
    chk("sat_hi_model", model(0, 24, 0), 8388607);
    run_vector(-1, 0, -1);
    foreach (xs[k]) xs[k] = 511;
    chk("sat_lo_model", model(0, 24, 0), -8388608);
    run_vector(-1, 0, -1);
    load(4);
    wr(200, 1234);
    foreach (xs[k]) xs[k] = int'($urandom_range(0, 1023)) - 512;
    run_vector(3, 1, -1);
    foreach (xs[k]) xs[k] = int'($urandom_range(0, 1023)) - 512;
    run_vector(-1, 0, 2);
    foreach (xs[k]) xs[k] = int'($urandom_range(0, 1023)) - 512;
    run_vector(-1, 0, -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Parametrised, time-multiplexed fully-connected layer.
- Takes one packed input vector of N_IN signed activations and produces N_OUT neuron results serially, one per output handshake.
- Uses LANES multipliers per cycle against an internally stored weight/bias memory, loaded through a write port.
- Sits after the final pooling stage and feeds the classifier/argmax stage.

Parameters:
- IN_W, 10: signed activation width.
- W_W, 16: signed weight/bias width.
- N_IN, 16: activations per vector; must be a multiple of LANES.
- N_OUT, 10: output neurons.
- LANES, 4: MACs per cycle.
- OUT_W, 32: signed result width (saturated).
- RELU, 0: 1 = clamp negative results to 0.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_valid  in  1  input vector valid
- o_ready  out  1  block idle, can accept vector/weight writes
- i_data  in  N_IN*IN_W  packed activations; element k at [k*IN_W +: IN_W]
- i_w_we  in  1  weight/bias write strobe
- i_w_addr  in  clog2(N_OUT*N_IN+N_OUT)  write address
- i_w_data  in  W_W  weight/bias value
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_result  out  OUT_W  neuron result
- o_idx  out  clog2(N_OUT)  neuron index of o_result
- o_last  out  1  high with o_valid on neuron N_OUT-1

Behaviour:
- Reset: i_reset is asynchronous, active-high; clock is i_clk.
- Reset values: o_valid=0, o_result=0, o_idx=0, o_last=0, o_ready=1, FSM=IDLE, accumulator=0.
- Weight memory is not reset; contents survive reset.
- Memory map: weight(n,k) at address n*N_IN+k; bias(n) at address N_OUT*N_IN+n. Addresses at or beyond N_OUT*N_IN+N_OUT are ignored.
- Writes take effect only when i_w_we=1 and FSM=IDLE; a write issued in any other state is dropped.
- B = N_IN/LANES.
- FSM IDLE:
  - o_ready=1.
  - On i_valid: latch i_data into the vector register, n=0, acc=0, go to MAC.
  - If i_valid and i_w_we are high in the same cycle, both take effect; the weight write is committed before neuron 0 reads memory.
- FSM MAC:
  - Runs B cycles, beat b=0..B-1.
  - Each beat: acc += sum over lanes l of x[b*LANES+l]*w(n, b*LANES+l).
  - After beat B-1: result = sat(acc+bias(n)), optionally ReLU; register into o_result; o_valid=1; o_idx=n; o_last=(n==N_OUT-1); go to OUT.
- FSM OUT:
  - Hold o_result/o_idx/o_last stable while o_valid=1 and i_ready=0.
  - On i_ready: o_valid drops next cycle.
  - If n<N_OUT-1: n++, acc=0, go to MAC. Otherwise go to IDLE, with o_ready=1 the cycle after the handshake.
- Latency: vector accepted at cycle T → neuron 0 o_valid at T+1+B.
  - With i_ready held high, each further neuron follows B+1 cycles later.
  - Defaults: T+5, T+10, …; full vector in N_OUT*(B+1)=50 cycles.
- Arithmetic:
  - Products are signed IN_W×W_W.
  - Accumulator is ACC_W = IN_W+W_W+clog2(N_IN+1) bits (defaults: 31), sign-extended.
  - Bias is sign-extended and added once.
  - sat(): clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1] when ACC_W+1 > OUT_W, otherwise plain sign-extension.
  - ReLU is applied after saturation.
- i_valid outside IDLE is ignored; the vector register is unchanged until the next IDLE accept.
- i_ready while o_valid=0 has no effect.
- Reset mid-MAC or mid-OUT aborts the vector immediately: no partial result and no further o_valid.

Test Plan:
- Load all weights=1, biases=0, i_data all elements=1, i_ready=1 → o_valid at T+5, o_result=16 for idx 0..9, o_last only on idx 9, o_ready back to 1 the cycle after the last handshake.
- Weights w(n,k)=n−5, bias(n)=100*n, activations=−2 → o_result(n)=−32*(n−5)+100*n, e.g. n=0: 160, n=9: 772. Same run with RELU=1 where bias=0 → n<5 outputs positive, n>5 outputs 0.
- Backpressure: i_ready low for 7 cycles on idx 3 → o_result/o_idx held stable, no MAC progress; idx 4 appears B+1 cycles after the release.
- Overflow: IN_W=10, W_W=16, OUT_W=24, all activations −512, all weights −32768 → product sum 2^28 saturates to 8388607. Activations 511 with weights −32768 → −8388608.
- i_w_we pulsed during MAC with new weight values → ignored; results match the pre-loaded weights. i_valid pulsed during OUT → ignored, no extra results.
- Assert i_reset during MAC of neuron 2 → o_valid=0 and o_ready=1 immediately. A new vector with the old weights yields correct results from idx 0.
